// File: rtl/fxp_mult_pkg.sv
// Shared defaults, stage payload shape and output scaling helper for fxp_mult_pipe.
// The saturating output build is selected with FXP_MULT_SAT_EN (see fxp_mult_pipe.sv).
package fxp_mult_pkg;

  localparam int W_DEF     = 32;
  localparam int F_DEF     = 16;
  localparam int M_DEF     = 24;
  localparam int TAG_W_DEF = 4;

  // S1 payload in the default configuration; the pipe re-declares it with its own widths.
  typedef struct packed {
    logic [M_DEF-1:0]     a_c;
    logic [M_DEF-1:0]     b_c;
    logic                 e_a;
    logic                 e_b;
    logic [TAG_W_DEF-1:0] tag;
  } s1_pay_t;

  // Each reduced operand carries an implicit 2^sh factor; the Q.F scaling removes f.
  function automatic int k_shift(input logic e_a, input logic e_b, input int sh, input int f);
    return sh * (2 - int'(e_a) - int'(e_b)) - f;
  endfunction

endpackage

// File: rtl/fxp_mult_pipe_if.sv
// Operand/result handshake bundle for fxp_mult_pipe: master = producer/consumer side, slave = block.
interface fxp_mult_pipe_if #(
  parameter int W     = 32,
  parameter int TAG_W = 4
);
  logic             in_valid;
  logic             in_ready;
  logic [W-1:0]     a_in;
  logic [W-1:0]     b_in;
  logic [TAG_W-1:0] tag_in;
  logic             out_valid;
  logic             out_ready;
  logic [W-1:0]     m_out;
  logic [TAG_W-1:0] tag_out;
  logic             approx_out;
  logic             ovf_out;

  modport master (
    output in_valid, a_in, b_in, tag_in, out_ready,
    input  in_ready, out_valid, m_out, tag_out, approx_out, ovf_out
  );

  modport slave (
    input  in_valid, a_in, b_in, tag_in, out_ready,
    output in_ready, out_valid, m_out, tag_out, approx_out, ovf_out
  );
endinterface

// File: rtl/fxp_operand_compress.sv
// Adaptive operand reduction: keep the low M bits when the value fits, else the top M bits.
module fxp_operand_compress #(
  parameter int W = 32,
  parameter int M = 24
) (
  input  logic [W-1:0] x,
  output logic [M-1:0] x_c,
  output logic         e
);
  localparam int SH = W - M;

  logic [W-M:0] hi;

  // Fits in M signed bits iff everything from the M-bit sign position upward agrees.
  assign hi  = x[W-1:M-1];
  assign e   = (hi == '0) || (hi == '1);
  assign x_c = e ? x[M-1:0] : x[W-1:SH];
endmodule

// File: rtl/fxp_mult_pipe.sv
// 3-stage signed fixed-point multiplier (compress, multiply, scale) with valid/ready flow control.
// Define FXP_MULT_SAT_EN to saturate m_out on overflow instead of wrapping.
module fxp_mult_pipe
  import fxp_mult_pkg::*;
#(
  parameter int W     = W_DEF,
  parameter int F     = F_DEF,
  parameter int M     = M_DEF,
  parameter int TAG_W = TAG_W_DEF
) (
  input logic           clk_in,
  input logic           rst_n_in,
  fxp_mult_pipe_if.slave bus
);
  localparam int SH     = W - M;
  localparam int PW     = 2 * M;
  localparam int RW     = 2 * W;
  localparam int STAGES = 3;

  typedef struct packed {
    logic [M-1:0]     a_c;
    logic [M-1:0]     b_c;
    logic             e_a;
    logic             e_b;
    logic [TAG_W-1:0] tag;
  } s1_t;

  typedef struct packed {
    logic [PW-1:0]    p;
    logic             e_a;
    logic             e_b;
    logic [TAG_W-1:0] tag;
  } s2_t;

  // Reset asserts asynchronously and releases on the clock.
  logic [1:0] rst_sq;
  logic       rst_n;

  always_ff @(posedge clk_in or negedge rst_n_in)
    if (!rst_n_in) rst_sq <= '0;
    else           rst_sq <= {rst_sq[0], 1'b1};

  assign rst_n = rst_sq[1];

  // Stage s may load when empty or when stage s+1 is loading; the last stage drains on out_ready.
  logic [STAGES:1] vld_pipe, vld_nxt, adv, ld;

  assign adv[3]  = ~vld_pipe[3] | bus.out_ready;
  assign adv[2]  = ~vld_pipe[2] | adv[3];
  assign adv[1]  = ~vld_pipe[1] | adv[2];
  assign vld_nxt = {vld_pipe[STAGES-1:1], bus.in_valid};
  assign ld      = adv & vld_nxt;

  always_ff @(posedge clk_in or negedge rst_n)
    if (!rst_n) vld_pipe <= '0;
    else        vld_pipe <= (adv & vld_nxt) | (~adv & vld_pipe);

  assign bus.in_ready = rst_n & adv[1];

  // S1: compress
  logic [M-1:0] a_c, b_c;
  logic         e_a, e_b;
  s1_t          s1_q;

  fxp_operand_compress #(.W(W), .M(M)) u_cmp_a (.x(bus.a_in), .x_c(a_c), .e(e_a));
  fxp_operand_compress #(.W(W), .M(M)) u_cmp_b (.x(bus.b_in), .x_c(b_c), .e(e_b));

  always_ff @(posedge clk_in or negedge rst_n)
    if (!rst_n) begin
      s1_q <= '0;
    end else if (ld[1]) begin
      s1_q.a_c <= a_c;
      s1_q.b_c <= b_c;
      s1_q.e_a <= e_a;
      s1_q.e_b <= e_b;
      s1_q.tag <= bus.tag_in;
    end

  // S2: multiply
  logic signed [PW-1:0] p_c;
  s2_t                  s2_q;

  assign p_c = PW'($signed(s1_q.a_c)) * PW'($signed(s1_q.b_c));

  always_ff @(posedge clk_in or negedge rst_n)
    if (!rst_n) begin
      s2_q <= '0;
    end else if (ld[2]) begin
      s2_q.p   <= p_c;
      s2_q.e_a <= s1_q.e_a;
      s2_q.e_b <= s1_q.e_b;
      s2_q.tag <= s1_q.tag;
    end

  // S3: scale back to Q(W-F).F at double width so overflow is visible
  logic signed [RW-1:0] p_x, r;
  int                   k;
  logic                 ovf_c;
  logic [W-1:0]         m_c;

  assign p_x = RW'($signed(s2_q.p));
  assign k   = k_shift(s2_q.e_a, s2_q.e_b, SH, F);

  always_comb begin
    r = '0;
    if (k >= 0) r = p_x <<< k;
    else        r = p_x >>> (-k);
  end

  assign ovf_c = ~((&r[RW-1:W-1]) | ~(|r[RW-1:W-1]));

`ifdef FXP_MULT_SAT_EN
  assign m_c = !ovf_c      ? r[W-1:0] :
               r[RW-1]     ? {1'b1, {(W-1){1'b0}}} :
                             {1'b0, {(W-1){1'b1}}};
`else
  assign m_c = r[W-1:0];
`endif

  logic [W-1:0]     m_q;
  logic [TAG_W-1:0] tag_q;
  logic             approx_q, ovf_q;

  always_ff @(posedge clk_in or negedge rst_n)
    if (!rst_n) begin
      m_q      <= '0;
      tag_q    <= '0;
      approx_q <= 1'b0;
      ovf_q    <= 1'b0;
    end else if (ld[3]) begin
      m_q      <= m_c;
      tag_q    <= s2_q.tag;
      approx_q <= ~(s2_q.e_a & s2_q.e_b);
      ovf_q    <= ovf_c;
    end

  assign bus.out_valid  = vld_pipe[3];
  assign bus.m_out      = m_q;
  assign bus.tag_out    = tag_q;
  assign bus.approx_out = approx_q;
  assign bus.ovf_out    = ovf_q;
endmodule

// File: tb/tb_fxp_mult_pipe.sv
// Directed bench for fxp_mult_pipe: hand-computed vectors, backpressure burst, mid-flight reset.
module tb_fxp_mult_pipe;
  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  int   errs  = 0;
  int   checks = 0;

  fxp_mult_pipe_if #(.W(32), .TAG_W(4)) bus ();

  fxp_mult_pipe #(.W(32), .F(16), .M(24), .TAG_W(4)) dut (
    .clk_in   (clk),
    .rst_n_in (rst_n),
    .bus      (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic chk(input string tg, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed=%h expected=%h", tg, obs, exp);
    end
  endtask

  // One isolated operation with out_ready high; latency counted in whole cycles.
  task automatic run_op(input string tg, input logic [31:0] a, input logic [31:0] b,
                        input logic [3:0] t, input logic [31:0] em,
                        input logic eapx, input logic eovf);
    int lat;
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.a_in     = a;
    bus.b_in     = b;
    bus.tag_in   = t;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      bus.in_valid = 1'b0;
    end while (!bus.out_valid && lat < 8);
    chk({tg, "_lat"},    32'(lat),       32'd3);
    chk({tg, "_m"},      bus.m_out,      em);
    chk({tg, "_tag"},    32'(bus.tag_out), 32'(t));
    chk({tg, "_approx"}, 32'(bus.approx_out), 32'(eapx));
    chk({tg, "_ovf"},    32'(bus.ovf_out),    32'(eovf));
  endtask

  logic [31:0] sat_pos, sat_neg;
  int sent, got, seen;

  initial begin
`ifdef FXP_MULT_SAT_EN
    sat_pos = 32'h7FFF_FFFF;
    sat_neg = 32'h8000_0000;
`else
    sat_pos = 32'h0000_0000;
    sat_neg = 32'h0000_0000;
`endif
    bus.in_valid  = 1'b0;
    bus.a_in      = '0;
    bus.b_in      = '0;
    bus.tag_in    = '0;
    bus.out_ready = 1'b0;

    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_ovalid", 32'(bus.out_valid),  32'd0);
    chk("rst_m",      bus.m_out,           32'd0);
    chk("rst_tag",    32'(bus.tag_out),    32'd0);
    chk("rst_approx", 32'(bus.approx_out), 32'd0);
    chk("rst_ovf",    32'(bus.ovf_out),    32'd0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);

    bus.out_ready = 1'b1;
    run_op("mul_1p5x2",  32'h0001_8000, 32'h0002_0000, 4'd1, 32'h0003_0000, 1'b0, 1'b0);
    run_op("mul_neg1x5", 32'hFFFF_0000, 32'h0005_0000, 4'd2, 32'hFFFB_0000, 1'b0, 1'b0);
    run_op("mul_256x2",  32'h0100_0000, 32'h0002_0000, 4'd3, 32'h0200_0000, 1'b1, 1'b0);
    run_op("ovf_pos",    32'h4000_0000, 32'h4000_0000, 4'd4, sat_pos,       1'b1, 1'b1);
    run_op("ovf_neg",    32'h4000_0000, 32'hC000_0000, 4'd5, sat_neg,       1'b1, 1'b1);
    run_op("zero",       32'h0000_0000, 32'h0005_0000, 4'd6, 32'h0000_0000, 1'b0, 1'b0);
    run_op("most_neg",   32'h8000_0000, 32'h0001_0000, 4'd7, 32'h8000_0000, 1'b1, 1'b0);
    run_op("trunc_neg",  32'hFFFF_8000, 32'h0000_0001, 4'd8, 32'hFFFF_FFFF, 1'b0, 1'b0);
    run_op("edge_exact", 32'h007F_FFFF, 32'h0001_0000, 4'd9, 32'h007F_FFFF, 1'b0, 1'b0);
    run_op("edge_red",   32'h0080_0000, 32'h0001_0000, 4'hA, 32'h0080_0000, 1'b1, 1'b0);
    run_op("red_trunc",  32'h0123_45FF, 32'h0001_0000, 4'hB, 32'h0123_4500, 1'b1, 1'b0);

    // Burst of five x*1.0 with the consumer stalled for the first six cycles.
    sent = 0;
    got  = 0;
    for (int c = 0; c < 40 && got < 5; c++) begin
      @(negedge clk);
      bus.out_ready = (c >= 6);
      bus.in_valid  = (sent < 5);
      bus.a_in      = 32'(sent + 1) << 16;
      bus.b_in      = 32'h0001_0000;
      bus.tag_in    = 4'(sent);
      #1;
      if (c == 3) chk("full_in_ready3", 32'(bus.in_ready), 32'd0);
      if (c == 5) begin
        chk("full_in_ready5", 32'(bus.in_ready),  32'd0);
        chk("full_accepted",  32'(sent),          32'd3);
        chk("stall_ovalid",   32'(bus.out_valid), 32'd1);
        chk("stall_m",        bus.m_out,          32'h0001_0000);
        chk("stall_tag",      32'(bus.tag_out),   32'd0);
      end
      if (c == 6) chk("full_pass_ready", 32'(bus.in_ready), 32'd1);
      if (bus.out_valid && bus.out_ready) begin
        chk("burst_tag", 32'(bus.tag_out), 32'(got));
        chk("burst_m",   bus.m_out,        32'(got + 1) << 16);
        got++;
      end
      if (bus.in_valid && bus.in_ready) sent++;
    end
    bus.in_valid = 1'b0;
    chk("burst_sent", 32'(sent), 32'd5);
    chk("burst_got",  32'(got),  32'd5);
    @(negedge clk);
    chk("burst_no_dup", 32'(bus.out_valid), 32'd0);

    // Two operations in flight, then reset while the first is waiting at the output.
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.a_in      = 32'h0001_0000;
    bus.b_in      = 32'h0001_0000;
    bus.tag_in    = 4'hC;
    @(negedge clk);
    bus.tag_in    = 4'hD;
    @(negedge clk);
    bus.in_valid  = 1'b0;
    for (int n = 0; n < 8 && !bus.out_valid; n++) @(negedge clk);
    chk("rst_pre_ovalid", 32'(bus.out_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_ovalid", 32'(bus.out_valid), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    seen = 0;
    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      if (bus.out_valid) seen++;
    end
    chk("rst_no_emit",   32'(seen),         32'd0);
    chk("rst_ready_post", 32'(bus.in_ready), 32'd1);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
